// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
//
// Sequences one conditional branch at a time through an external combinational
// comparator, then reports whether the branch was taken, the next PC, and
// requests a pipeline flush for FLUSH_CYCLES cycles after a taken branch.
//
// Flow: IDLE -> CMP -> RESOLVE -> (FLUSH x FLUSH_CYCLES) -> IDLE
//
// Handshake: br_valid/br_ready. A request transfers on a rising clk edge
// where br_valid=1 and br_ready=1. br_ready is high only in IDLE. The
// requester holds br_* stable until the transfer, and br_* are ignored in
// every other state.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   br_valid/br_ready request handshake
//   br_op             000 never, 001 eq, 010 lt, 011 gt, 100 always,
//                     101-111 illegal
//   br_r0, br_op1     compare operands
//   br_pc, br_offset  branch address and signed 12-bit word offset
//   cmp_r0/op1/ctrl   registered operands and code for the comparator
//   cmp_pcsrc         comparator result, sampled at the end of CMP
//   res_valid         one-cycle strobe in RESOLVE
//   res_taken/target/err  result fields, held until the next RESOLVE
//   flush             high for FLUSH_CYCLES cycles after a taken branch
//   taken_count       saturating count of taken branches
//
// The current state is available as the internal signal state_q.
// ----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_op,
    input  logic [15:0] br_r0,
    input  logic [15:0] br_op1,
    input  logic [15:0] br_pc,
    input  logic [11:0] br_offset,
    output logic [15:0] cmp_r0,
    output logic [15:0] cmp_op1,
    output logic [2:0]  cmp_ctrl,
    input  logic        cmp_pcsrc,
    output logic        res_valid,
    output logic        res_taken,
    output logic [15:0] res_target,
    output logic        res_err,
    output logic        flush,
    output logic [7:0]  taken_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP     = 2'd1,
        RESOLVE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] r0_q, r0_d;
    logic [15:0] op1_q, op1_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        illegal_q, illegal_d;
    logic [15:0] pc_q, pc_d;
    logic [11:0] off_q, off_d;
    logic        taken_q, taken_d;
    logic [15:0] target_q, target_d;
    logic        err_q, err_d;
    logic [7:0]  count_q, count_d;

    // Byte offset: sign-extend the word offset to 16 bits and shift left by one.
    logic [15:0] off_bytes;
    assign off_bytes = {{3{off_q[11]}}, off_q, 1'b0};

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        r0_d        = r0_q;
        op1_d       = op1_q;
        ctrl_d      = ctrl_q;
        illegal_d   = illegal_q;
        pc_d        = pc_q;
        off_d       = off_q;
        taken_d     = taken_q;
        target_d    = target_q;
        err_d       = err_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    state_d   = CMP;
                    r0_d      = br_r0;
                    op1_d     = br_op1;
                    illegal_d = (br_op > 3'd4);
                    // Illegal codes present "never" to the comparator.
                    ctrl_d    = (br_op > 3'd4) ? 3'd0 : br_op;
                    pc_d      = br_pc;
                    off_d     = br_offset;
                end
            end
            CMP: begin
                state_d  = RESOLVE;
                taken_d  = ~illegal_q & cmp_pcsrc;
                err_d    = illegal_q;
                target_d = taken_d ? (pc_q + off_bytes) : (pc_q + 16'd2);
                if (taken_d && (count_q != 8'hFF)) begin
                    count_d = count_q + 8'd1;
                end
            end
            RESOLVE: begin
                if (taken_q) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= 3'd0;
            r0_q        <= 16'd0;
            op1_q       <= 16'd0;
            ctrl_q      <= 3'd0;
            illegal_q   <= 1'b0;
            pc_q        <= 16'd0;
            off_q       <= 12'd0;
            taken_q     <= 1'b0;
            target_q    <= 16'd0;
            err_q       <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            r0_q        <= r0_d;
            op1_q       <= op1_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
            pc_q        <= pc_d;
            off_q       <= off_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign br_ready    = (state_q == IDLE);
    assign res_valid   = (state_q == RESOLVE);
    assign flush       = (state_q == FLUSH);
    assign cmp_r0      = r0_q;
    assign cmp_op1     = op1_q;
    assign cmp_ctrl    = ctrl_q;
    assign res_taken   = taken_q;
    assign res_target  = target_q;
    assign res_err     = err_q;
    assign taken_count = count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_branch_sequencer
//
// Directed bench for branch_sequencer. A behavioural model tracks each
// accepted branch by "cycles since acceptance" and computes the outcome
// directly from the branch rules; every cycle the DUT outputs are compared to
// it at the falling edge. A table of hand-computed results pins the model.
// ----------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_op;
    logic [15:0] br_r0;
    logic [15:0] br_op1;
    logic [15:0] br_pc;
    logic [11:0] br_offset;
    logic [15:0] cmp_r0;
    logic [15:0] cmp_op1;
    logic [2:0]  cmp_ctrl;
    logic        cmp_pcsrc;
    logic        res_valid;
    logic        res_taken;
    logic [15:0] res_target;
    logic        res_err;
    logic        flush;
    logic [7:0]  taken_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.FLUSH_CYCLES(F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_op       (br_op),
        .br_r0       (br_r0),
        .br_op1      (br_op1),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .cmp_r0      (cmp_r0),
        .cmp_op1     (cmp_op1),
        .cmp_ctrl    (cmp_ctrl),
        .cmp_pcsrc   (cmp_pcsrc),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .res_err     (res_err),
        .flush       (flush),
        .taken_count (taken_count)
    );

    // External comparator. Codes 101-111 answer 1 so that an unmasked
    // illegal code would show up as a taken branch.
    always_comb begin
        case (cmp_ctrl)
            3'b000:  cmp_pcsrc = 1'b0;
            3'b001:  cmp_pcsrc = (cmp_r0 == cmp_op1);
            3'b010:  cmp_pcsrc = (cmp_r0 < cmp_op1);
            3'b011:  cmp_pcsrc = (cmp_r0 > cmp_op1);
            3'b100:  cmp_pcsrc = 1'b1;
            default: cmp_pcsrc = 1'b1;
        endcase
    end

    // ---------------- behavioural model ----------------
    // m_since: -1 when idle, else cycles elapsed since the accepting edge
    // (1 = compare cycle, 2 = result cycle, 3.. = flush cycles).
    int          m_since  = -1;
    int          m_total  = 3;
    int          m_count  = 0;
    logic        p_taken  = 1'b0;
    logic [15:0] p_target = 16'd0;
    logic        p_err    = 1'b0;
    logic        h_taken  = 1'b0;
    logic [15:0] h_target = 16'd0;
    logic        h_err    = 1'b0;
    logic [15:0] m_r0     = 16'd0;
    logic [15:0] m_op1    = 16'd0;
    logic [2:0]  m_ctrl   = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since  = -1;
            m_total  = 3;
            m_count  = 0;
            h_taken  = 1'b0;
            h_target = 16'd0;
            h_err    = 1'b0;
            m_r0     = 16'd0;
            m_op1    = 16'd0;
            m_ctrl   = 3'd0;
        end else if (m_since < 0) begin
            if (br_valid) begin
                int off_i;
                m_since = 1;
                m_r0    = br_r0;
                m_op1   = br_op1;
                m_ctrl  = (br_op <= 3'd4) ? br_op : 3'd0;
                p_err   = (br_op > 3'd4);
                case (br_op)
                    3'd1:    p_taken = (br_r0 == br_op1);
                    3'd2:    p_taken = (br_r0 < br_op1);
                    3'd3:    p_taken = (br_r0 > br_op1);
                    3'd4:    p_taken = 1'b1;
                    default: p_taken = 1'b0;
                endcase
                off_i    = int'($signed(br_offset));
                p_target = p_taken ? 16'(int'(br_pc) + off_i * 2) : 16'(int'(br_pc) + 2);
                m_total  = p_taken ? 3 + F : 3;
            end
        end else begin
            m_since = m_since + 1;
            if (m_since == 2) begin
                h_taken  = p_taken;
                h_target = p_target;
                h_err    = p_err;
                if (p_taken && m_count < 255) m_count = m_count + 1;
            end
            if (m_since == m_total) m_since = -1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("br_ready",    32'(br_ready),    32'(m_since < 0));
        check("res_valid",   32'(res_valid),   32'(m_since == 2));
        check("flush",       32'(flush),       32'(m_since >= 3));
        check("taken_count", 32'(taken_count), 32'(m_count));
        check("res_taken",   32'(res_taken),   32'(h_taken));
        check("res_target",  32'(res_target),  32'(h_target));
        check("res_err",     32'(res_err),     32'(h_err));
        check("cmp_ctrl",    32'(cmp_ctrl),    32'(m_ctrl));
        check("cmp_r0",      32'(cmp_r0),      32'(m_r0));
        check("cmp_op1",     32'(cmp_op1),     32'(m_op1));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (m_since >= 0 && g < 40) begin
            tick();
            g++;
        end
        check("idle_timeout", 32'(m_since >= 0), 32'd0);
    endtask

    // Presents a request and returns at the falling edge of the compare cycle.
    task automatic run_branch(input logic [2:0] op, input logic [15:0] r0, input logic [15:0] op1,
                              input logic [15:0] pc, input logic [11:0] off, input bit hold);
        br_op     = op;
        br_r0     = r0;
        br_op1    = op1;
        br_pc     = pc;
        br_offset = off;
        br_valid  = 1'b1;
        wait_idle();
        tick();
        if (!hold) begin
            // Scramble the inputs after acceptance; the DUT must ignore them.
            br_valid  = 1'b0;
            br_r0     = ~r0;
            br_op1    = r0;
            br_pc     = ~pc;
            br_offset = ~off;
            br_op     = 3'd4;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] r0;
        logic [15:0] op1;
        logic [15:0] pc;
        logic [11:0] off;
        logic        taken;
        logic [15:0] target;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{3'd1, 16'h4545, 16'h4545, 16'h0100, 12'h010, 1'b1, 16'h0120, 1'b0};
        vecs[1]  = '{3'd1, 16'h4545, 16'h4546, 16'h0100, 12'h010, 1'b0, 16'h0102, 1'b0};
        vecs[2]  = '{3'd4, 16'h0000, 16'h0000, 16'hFFFE, 12'h001, 1'b1, 16'h0000, 1'b0};
        vecs[3]  = '{3'd4, 16'h0000, 16'h0000, 16'h0000, 12'hFFF, 1'b1, 16'hFFFE, 1'b0};
        vecs[4]  = '{3'd6, 16'h0001, 16'h0001, 16'h0200, 12'h010, 1'b0, 16'h0202, 1'b1};
        vecs[5]  = '{3'd2, 16'h0010, 16'h0020, 16'h1000, 12'h7FF, 1'b1, 16'h1FFE, 1'b0};
        vecs[6]  = '{3'd3, 16'h0010, 16'h0020, 16'h1000, 12'h7FF, 1'b0, 16'h1002, 1'b0};
        vecs[7]  = '{3'd0, 16'h0005, 16'h0005, 16'h0300, 12'h004, 1'b0, 16'h0302, 1'b0};
        vecs[8]  = '{3'd2, 16'h0020, 16'h0010, 16'h2000, 12'h800, 1'b0, 16'h2002, 1'b0};
        vecs[9]  = '{3'd3, 16'h8000, 16'h7FFF, 16'h2000, 12'h800, 1'b1, 16'h1000, 1'b0};
        vecs[10] = '{3'd7, 16'h0001, 16'h0002, 16'h0400, 12'h010, 1'b0, 16'h0402, 1'b1};

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_op     = 3'd0;
        br_r0     = 16'd0;
        br_op1    = 16'd0;
        br_pc     = 16'd0;
        br_offset = 12'd0;
        tick();
        tick();
        check("rst_target", 32'(res_target), 32'h0000);
        check("rst_count",  32'(taken_count), 32'h00);
        check("rst_flush",  32'(flush), 32'd0);
        #2 rst_n = 1'b1;
        #1 check("ready_after_rst", 32'(br_ready), 32'd1);

        // ---------------- directed table ----------------
        for (int i = 0; i < 11; i++) begin
            run_branch(vecs[i].op, vecs[i].r0, vecs[i].op1, vecs[i].pc, vecs[i].off, 1'b0);
            check("lit_valid_pending", 32'(res_valid), 32'd0);
            tick();
            check("lit_res_valid",  32'(res_valid),  32'd1);
            check("lit_res_taken",  32'(res_taken),  32'(vecs[i].taken));
            check("lit_res_target", 32'(res_target), 32'(vecs[i].target));
            check("lit_res_err",    32'(res_err),    32'(vecs[i].err));
            if (vecs[i].op > 3'd4) check("lit_cmp_ctrl", 32'(cmp_ctrl), 32'd0);
            tick();
            check("lit_flush_first", 32'(flush), 32'(vecs[i].taken));
            check("lit_ready_back",  32'(br_ready), 32'(!vecs[i].taken));
            wait_idle();
        end
        check("lit_count_after_table", 32'(taken_count), 32'd5);

        // ---------------- reset during the second flush cycle ----------------
        run_branch(3'd1, 16'h4545, 16'h4545, 16'h0100, 12'h010, 1'b0);
        tick();
        tick();
        tick();
        check("lit_flush_2nd", 32'(flush), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("lit_rst_flush", 32'(flush), 32'd0);
        check("lit_rst_count", 32'(taken_count), 32'h00);
        tick();
        tick();
        #2 rst_n = 1'b1;
        #1 check("lit_ready_release", 32'(br_ready), 32'd1);
        tick();
        check("lit_ready_release_cyc", 32'(br_ready), 32'd1);

        // ---------------- saturation, back-to-back requests ----------------
        for (int i = 0; i < 256; i++) begin
            run_branch(3'd4, 16'd0, 16'd0, 16'(i * 4), 12'h001, 1'b1);
        end
        br_valid = 1'b0;
        wait_idle();
        check("lit_sat_256", 32'(taken_count), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            run_branch(3'd4, 16'd0, 16'd0, 16'h0800, 12'h002, 1'b0);
            wait_idle();
        end
        check("lit_sat_hold", 32'(taken_count), 32'hFF);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
